// File: rtl/present_inv_key_sched.sv
// PRESENT inverse key schedule: runs the forward schedule from the master key
// up to the last round key, then walks it back and emits round keys from the
// last one down to round key 1, one per accepted valid/ready handshake.
module present_inv_key_sched #(
  parameter int KEY_SIZE   = 80,
  parameter int NUM_ROUNDS = 31
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_SIZE-1:0] orig_key,
  input  logic                abort,
  output logic [63:0]         key_out,
  output logic [5:0]          key_idx,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                busy,
  output logic                done
);

  // Round-counter XOR lands at [19:15] for 80-bit keys, [66:62] for 128-bit.
  localparam int          XOR_LO   = (KEY_SIZE == 128) ? 62 : 15;
  localparam logic [4:0]  LAST_CNT = 5'(NUM_ROUNDS);
  localparam logic [5:0]  LAST_IDX = 6'(NUM_ROUNDS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORWARD = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [KEY_SIZE-1:0] key_reg, key_nxt;
  logic [4:0]          cnt, cnt_nxt;
  logic [63:0]         key_out_nxt;
  logic [5:0]          key_idx_nxt;
  logic [5:0]          idx_dec;
  logic                key_valid_nxt;
  logic                done_nxt;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    case (x)
      4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;  4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
      4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;  4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
      4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;  4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
      4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;  4'hE: sbox_inv = 4'h9;  default: sbox_inv = 4'hA;
    endcase
  endfunction

  // One forward schedule update: rotate left 61, S-box top nibble(s), XOR round counter.
  function automatic logic [KEY_SIZE-1:0] fwd_step(input logic [KEY_SIZE-1:0] k,
                                                   input logic [4:0]          rc);
    logic [KEY_SIZE-1:0] r;
    r = {k[KEY_SIZE-62:0], k[KEY_SIZE-1:KEY_SIZE-61]};
    r[KEY_SIZE-1 -: 4] = sbox(r[KEY_SIZE-1 -: 4]);
    if (KEY_SIZE == 128) r[KEY_SIZE-5 -: 4] = sbox(r[KEY_SIZE-5 -: 4]);
    r[XOR_LO +: 5] = r[XOR_LO +: 5] ^ rc;
    fwd_step = r;
  endfunction

  // Exact undo of fwd_step: XOR counter, inverse S-box, rotate right 61.
  function automatic logic [KEY_SIZE-1:0] inv_step(input logic [KEY_SIZE-1:0] k,
                                                   input logic [4:0]          rc);
    logic [KEY_SIZE-1:0] r;
    r = k;
    r[XOR_LO +: 5] = r[XOR_LO +: 5] ^ rc;
    r[KEY_SIZE-1 -: 4] = sbox_inv(r[KEY_SIZE-1 -: 4]);
    if (KEY_SIZE == 128) r[KEY_SIZE-5 -: 4] = sbox_inv(r[KEY_SIZE-5 -: 4]);
    inv_step = {r[60:0], r[KEY_SIZE-1:61]};
  endfunction

  assign busy    = (state != IDLE);
  assign idx_dec = key_idx - 6'd1;

  // Next-state and datapath updates for the three-state sequencer.
  always_comb begin
    state_nxt     = state;
    key_nxt       = key_reg;
    cnt_nxt       = cnt;
    key_out_nxt   = key_out;
    key_idx_nxt   = key_idx;
    key_valid_nxt = key_valid;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          key_nxt   = orig_key;
          cnt_nxt   = 5'd1;
          state_nxt = FORWARD;
        end
      end
      FORWARD: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          key_nxt = fwd_step(key_reg, cnt);
          if (cnt == LAST_CNT) state_nxt = OUTPUT;
          else                 cnt_nxt   = cnt + 5'd1;
        end
      end
      OUTPUT: begin
        if (abort) begin
          key_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end else if (!key_valid) begin
          // First OUTPUT cycle: publish the last round key held in key_reg.
          key_out_nxt   = key_reg[KEY_SIZE-1 -: 64];
          key_idx_nxt   = LAST_IDX;
          key_valid_nxt = 1'b1;
        end else if (key_ready) begin
          if (key_idx == 6'd1) begin
            key_valid_nxt = 1'b0;
            done_nxt      = 1'b1;
            state_nxt     = IDLE;
          end else begin
            key_nxt     = inv_step(key_reg, idx_dec[4:0]);
            key_out_nxt = key_nxt[KEY_SIZE-1 -: 64];
            key_idx_nxt = idx_dec;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, working key and output registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      key_reg   <= '0;
      cnt       <= '0;
      key_out   <= '0;
      key_idx   <= '0;
      key_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      key_reg   <= key_nxt;
      cnt       <= cnt_nxt;
      key_out   <= key_out_nxt;
      key_idx   <= key_idx_nxt;
      key_valid <= key_valid_nxt;
      done      <= done_nxt;
    end
  end

endmodule
